neuron_mac: RTL and testbench

Two-input neuron pre-activation stage: computes the weighted sum `x0*w0 + x1*w1 + bias` in signed fixed point, then hands the result to the activation (sigmoid) stage through a valid/ready handshake. It sits directly upstream of the activation stage and owns its weight and bias registers, which are loaded through a simple write port. A single multiplier is time-shared across a small FSM, so one sum takes three cycles.

---
 rtl/neuron_pkg.sv | 54 +++++
 rtl/neuron_weight_regs.sv | 66 ++++++
 rtl/neuron_mac.sv | 165 ++++++++++++++++
 tb/tb_neuron_mac.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Package     : neuron_pkg
// Description : Shared types, constants and the scale/saturate helper used by
//               the neuron pre-activation stages.
// Revision    : 1.0  initial release
// ============================================================================
package neuron_pkg;

    // Default Q8.8 fixed-point format
    localparam int DEF_DW   = 16;
    localparam int DEF_FRAC = 8;

    // Weight write-port addresses (address 3 is ignored)
    localparam logic [1:0] W0_ADDR   = 2'd0;
    localparam logic [1:0] W1_ADDR   = 2'd1;
    localparam logic [1:0] BIAS_ADDR = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        BIAS = 3'd3,
        OUT  = 3'd4
    } mac_state_t;

    // Reduces an already-scaled value to dw bits. Returns {ovf, value}; the
    // caller keeps the low dw bits of value. Without saturation the low bits
    // are simply taken, which is a two's-complement wrap.
    function automatic logic [64:0] sat_trunc(
        input logic signed [63:0] scaled,
        input int                 dw,
        input logic               sat_en
    );
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        logic signed [63:0] v_res;
        logic               v_ovf;
        v_max = (64'sd1 <<< (dw - 1)) - 64'sd1;
        v_min = -v_max - 64'sd1;
        v_res = scaled;
        v_ovf = 1'b0;
        if (sat_en && (scaled > v_max)) begin
            v_res = v_max;
            v_ovf = 1'b1;
        end else if (sat_en && (scaled < v_min)) begin
            v_res = v_min;
            v_ovf = 1'b1;
        end
        return {v_ovf, v_res};
    endfunction

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/neuron_weight_regs.sv
`default_nettype none
// ============================================================================
// Module      : neuron_weight_regs
// Description : Write-addressable w0/w1/bias registers plus the working copies
//               snapshotted when an input pair is accepted.
// Revision    : 1.0  initial release
// ============================================================================
module neuron_weight_regs
    import neuron_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [1:0]    i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_snap,
    output logic [DW-1:0] o_w0,
    output logic [DW-1:0] o_w1,
    output logic [DW-1:0] o_bias
);

    logic [DW-1:0] r_w0;
    logic [DW-1:0] r_w1;
    logic [DW-1:0] r_bias;
    logic [DW-1:0] r_w0_snap;
    logic [DW-1:0] r_w1_snap;
    logic [DW-1:0] r_bias_snap;

    // Live registers: written from the port at any time, address 3 dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w0   <= '0;
            r_w1   <= '0;
            r_bias <= '0;
        end else if (i_we) begin
            case (i_addr)
                W0_ADDR:   r_w0   <= i_data;
                W1_ADDR:   r_w1   <= i_data;
                BIAS_ADDR: r_bias <= i_data;
                default:   ;
            endcase
        end
    end

    // Working copies: take the pre-edge live values on accept so a write
    // landing mid-sum only affects the next pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w0_snap   <= '0;
            r_w1_snap   <= '0;
            r_bias_snap <= '0;
        end else if (i_snap) begin
            r_w0_snap   <= r_w0;
            r_w1_snap   <= r_w1;
            r_bias_snap <= r_bias;
        end
    end

    assign o_w0   = r_w0_snap;
    assign o_w1   = r_w1_snap;
    assign o_bias = r_bias_snap;

endmodule : neuron_weight_regs
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Two-input neuron pre-activation stage computing
//               x0*w0 + x1*w1 + bias with one time-shared multiplier and a
//               valid/ready output towards the activation stage.
//               Define NEURON_SAT_EN to clip the result and drive ovf;
//               otherwise the result wraps and ovf is tied low.
// Revision    : 1.0  initial release
// ============================================================================
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int FRAC  = DEF_FRAC,
    parameter int ACC_W = 2*DW + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic          w_we,
    input  logic [1:0]    w_addr,
    input  logic [DW-1:0] w_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] sum,
    output logic          ovf
);

`ifdef NEURON_SAT_EN
    localparam logic c_SAT_EN = 1'b1;
`else
    localparam logic c_SAT_EN = 1'b0;
`endif

    mac_state_t               r_state;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [DW-1:0]     r_x0;
    logic signed [DW-1:0]     r_x1;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DW-1:0]            r_sum;

    logic                     w_accept;
    logic [DW-1:0]            w_w0_s;
    logic [DW-1:0]            w_w1_s;
    logic [DW-1:0]            w_bias_s;
    logic signed [DW-1:0]     w_mul_a;
    logic signed [DW-1:0]     w_mul_b;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_acc_bias;
    logic signed [63:0]       w_scaled;
    logic [64:0]              w_st;
    logic                     w_unused;

    assign w_accept = in_valid && r_in_ready;

    neuron_weight_regs #(
        .DW (DW)
    ) u_weight_regs (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_data (w_data),
        .i_snap (w_accept),
        .o_w0   (w_w0_s),
        .o_w1   (w_w1_s),
        .o_bias (w_bias_s)
    );

    // Single multiplier: x0*w0 in MUL0, x1*w1 otherwise
    assign w_mul_a    = (r_state == MUL0) ? r_x0 : r_x1;
    assign w_mul_b    = (r_state == MUL0) ? $signed(w_w0_s) : $signed(w_w1_s);
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = ACC_W'(w_prod);

    // Bias is Q.FRAC; shift it up to the product's Q.2FRAC alignment
    assign w_bias_ext = ACC_W'($signed(w_bias_s)) <<< FRAC;
    assign w_acc_bias = r_acc + w_bias_ext;

    // Arithmetic shift floors toward minus infinity
    assign w_scaled = 64'(w_acc_bias >>> FRAC);
    assign w_st     = sat_trunc(w_scaled, DW, c_SAT_EN);

    // Control FSM with registered handshake outputs and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x0       <= $signed(x0);
                        r_x1       <= $signed(x1);
                        r_in_ready <= 1'b0;
                        r_state    <= MUL0;
                    end
                end
                MUL0: begin
                    r_acc   <= w_prod_ext;
                    r_state <= MUL1;
                end
                MUL1: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= BIAS;
                end
                BIAS: begin
                    r_acc       <= w_acc_bias;
                    r_sum       <= w_st[DW-1:0];
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef NEURON_SAT_EN
    logic r_ovf;

    // Clip flag captured alongside the result so it is valid with sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == BIAS) begin
            r_ovf <= w_st[64];
        end
    end

    assign ovf      = r_ovf;
    assign w_unused = ^w_st[63:DW];
`else
    assign ovf      = 1'b0;
    assign w_unused = ^w_st[64:DW];
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;

endmodule : neuron_mac
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac
// Description : Scoreboard bench for neuron_mac. Expected {ovf,sum} values are
//               queued at acceptance from an arithmetic reference model and
//               popped by a monitor whenever an output handshake occurs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x0 = '0;
    logic [15:0] x1 = '0;
    logic        w_we = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      acc_edge = 0;
    logic [16:0] exp_q[$];
    logic [15:0] lw0 = '0, lw1 = '0, lb = '0;
    logic [15:0] last_sum = '0;
    logic        last_ovf = 1'b0;
    logic [15:0] prev_sum = '0;
    bit          hs_prev = 0, hold_prev = 0, ov_prev = 0;
    bit          rand_bp = 0;

    neuron_mac u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: floor((x0*w0 + x1*w1 + bias*256) / 256), then wrap or clip
    function automatic logic [16:0] model(input logic [15:0] a0, a1, k0, k1, kb);
        longint total;
        longint scaled;
        total  = longint'($signed(a0)) * longint'($signed(k0))
               + longint'($signed(a1)) * longint'($signed(k1))
               + longint'($signed(kb)) * 256;
        scaled = total >>> 8;
`ifdef NEURON_SAT_EN
        if (scaled > 32767)  return {1'b1, 16'h7FFF};
        if (scaled < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, scaled[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor (pop/compare) followed by reference model (push on accept)
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            lw0 = '0; lw1 = '0; lb = '0;
            hs_prev = 0; hold_prev = 0; ov_prev = 0;
        end else begin
            if (hs_prev) begin
                check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
                check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
            end
            if (out_valid && !ov_prev)
                check("latency", 32'(cyc - acc_edge), 32'd3);
            if (hold_prev && out_valid) begin
                check("sum_stable_under_backpressure", {16'd0, sum}, {16'd0, prev_sum});
                check("in_ready_low_in_out", {31'd0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum 0x%0h, expected no output", sum);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("sum", {16'd0, sum}, {16'd0, e[15:0]});
                    check("ovf", {31'd0, ovf}, {31'd0, e[16]});
                end
                last_sum = sum;
                last_ovf = ovf;
            end
            hs_prev   = out_valid && out_ready;
            hold_prev = out_valid && !out_ready;
            ov_prev   = out_valid;
            prev_sum  = sum;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(x0, x1, lw0, lw1, lb));
                acc_edge = cyc + 1;
            end
            if (w_we) begin
                case (w_addr)
                    2'd0: lw0 = w_data;
                    2'd1: lw1 = w_data;
                    2'd2: lb  = w_data;
                    default: ;
                endcase
            end
        end
    end

    // Random back-pressure while enabled
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        w_we = 1'b1; w_addr = a; w_data = d;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; x0 = a; x1 = b;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) break;
            n++;
        end
        if (n == 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic sum
        wr(2'd0, 16'h0100); wr(2'd1, 16'h0080); wr(2'd2, 16'hFFC0);
        send(16'h0200, 16'h0400);
        wait_done();
        check("basic_sum", {16'd0, last_sum}, 32'h03C0);
        check("basic_ovf", {31'd0, last_ovf}, 32'd0);

        // Overflow
        wr(2'd0, 16'h7FFF); wr(2'd1, 16'h0000); wr(2'd2, 16'h0000);
        send(16'h7FFF, 16'h0000);
        wait_done();
`ifdef NEURON_SAT_EN
        check("ovf_sum", {16'd0, last_sum}, 32'h7FFF);
        check("ovf_flag", {31'd0, last_ovf}, 32'd1);
`else
        check("ovf_sum", {16'd0, last_sum}, 32'hFF00);
        check("ovf_flag", {31'd0, last_ovf}, 32'd0);
`endif

        // Negative rounding toward minus infinity
        wr(2'd0, 16'h0001);
        send(16'hFFFF, 16'h1234);
        wait_done();
        check("neg_round_sum", {16'd0, last_sum}, 32'hFFFF);

        // Back-pressure with a pending input pair
        wr(2'd1, 16'h0100); wr(2'd2, 16'h0010);
        out_ready = 1'b0;
        send(16'h0300, 16'h0050);
        in_valid = 1'b1; x0 = 16'h0011; x1 = 16'h0022;
        n = 0;
        while (n < 50 && !out_valid) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        send(16'h0011, 16'h0022);
        wait_done();

        // Weight write during MUL1 affects only the next pair
        wr(2'd0, 16'h0100); wr(2'd1, 16'h0000); wr(2'd2, 16'h0000);
        send(16'h0100, 16'h0000);
        @(posedge clk); #1;
        w_we = 1'b1; w_addr = 2'd0; w_data = 16'h0200;
        @(posedge clk); #1;
        w_we = 1'b0;
        wait_done();
        check("busy_write_old_w0", {16'd0, last_sum}, 32'h0100);
        send(16'h0100, 16'h0000);
        wait_done();
        check("busy_write_new_w0", {16'd0, last_sum}, 32'h0200);

        // Reset in BIAS: partial sum discarded, weights cleared
        wr(2'd1, 16'h0300); wr(2'd2, 16'h0040);
        send(16'h0100, 16'h0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        send(16'h0100, 16'h0100);
        wait_done();
        check("post_reset_sum", {16'd0, last_sum}, 32'd0);

        // Randomized traffic with random writes and back-pressure
        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr(2'($urandom_range(0, 3)), 16'($urandom));
            send(16'($urandom), 16'($urandom));
        end
        rand_bp = 0;
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_neuron_mac
`default_nettype wire
